// File: rtl/fifo_ring_fwft_if.sv
// ---------------------------------------------------------------------------
// fifo_ring_fwft_if
//   Write/read handshake bundle for fifo_ring_fwft.
//
//   Signals (names are from the FIFO's point of view):
//     i_wr_valid  producer -> FIFO   write request
//     i_wr_data   producer -> FIFO   write data, RAM_WIDTH bits
//     o_wr_ready  FIFO -> producer   space available
//     o_rd_valid  FIFO -> consumer   o_rd_data holds the oldest word
//     o_rd_data   FIFO -> consumer   head of queue, RAM_WIDTH bits
//     i_rd_ready  consumer -> FIFO   consumer accepts the head word
//
//   Modports:
//     master  the side that drives the FIFO (producer/consumer, testbench)
//     slave   the FIFO itself
// ---------------------------------------------------------------------------
interface fifo_ring_fwft_if #(
    parameter int RAM_WIDTH = 32
);
    logic                 i_wr_valid;
    logic [RAM_WIDTH-1:0] i_wr_data;
    logic                 o_wr_ready;
    logic                 o_rd_valid;
    logic [RAM_WIDTH-1:0] o_rd_data;
    logic                 i_rd_ready;

    modport master (
        output i_wr_valid,
        output i_wr_data,
        output i_rd_ready,
        input  o_wr_ready,
        input  o_rd_valid,
        input  o_rd_data
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_data,
        input  i_rd_ready,
        output o_wr_ready,
        output o_rd_valid,
        output o_rd_data
    );
endinterface

// File: rtl/fifo_ring_fwft.sv
// ---------------------------------------------------------------------------
// fifo_ring_fwft
//   Single-clock first-word-fall-through FIFO built on a circular RAM with a
//   synchronous read stage and one output register. Total capacity is
//   RAM_DEPTH words; o_fill_count counts every word held anywhere inside.
//
//   Parameters:
//     RAM_WIDTH  data word width in bits
//     RAM_DEPTH  capacity in words (power of two, >= 4)
//     AF_THRESH  o_almost_full  when o_fill_count >= AF_THRESH
//     AE_THRESH  o_almost_empty when o_fill_count <= AE_THRESH
//
//   Ports:
//     clk             rising-edge clock
//     rst             synchronous, active-high reset
//     bus (slave)     write/read handshake, see fifo_ring_fwft_if
//     o_fill_count    words held, including the output register
//     o_almost_full   threshold flag from the registered count
//     o_almost_empty  threshold flag from the registered count
//     i_clear_err     clears the sticky error state
//     o_overflow      sticky: a write was attempted while o_wr_ready=0
//     o_drop_count    16-bit saturating count of refused writes
//                     (present only with FIFO_RING_DROP_COUNT_EN defined)
//
//   Optional feature macro: FIFO_RING_DROP_COUNT_EN
//
//   Data path: RAM -> r_mid_data (synchronous RAM read) -> r_out_data.
//   A word written into an empty FIFO at edge k is fetched at k+1 and lands
//   in the output register at k+2. Both stages advance together whenever the
//   consumer takes a word, so reads sustain one per cycle.
// ---------------------------------------------------------------------------
module fifo_ring_fwft #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 1024,
    parameter int AF_THRESH = RAM_DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    fifo_ring_fwft_if.slave              bus,
    output logic [$clog2(RAM_DEPTH):0]   o_fill_count,
    output logic                         o_almost_full,
    output logic                         o_almost_empty,
    input  logic                         i_clear_err,
    output logic                         o_overflow
`ifdef FIFO_RING_DROP_COUNT_EN
    ,
    output logic [15:0]                  o_drop_count
`endif
);

    localparam int PTR_W = $clog2(RAM_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(RAM_DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Storage and pointers
    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_ram_count;   // words in RAM not yet fetched
    logic [CNT_W-1:0]     r_fill_count;  // all words held

    // Read pipeline
    logic                 r_mid_valid;
    logic [RAM_WIDTH-1:0] r_mid_data;
    logic                 r_out_valid;
    logic [RAM_WIDTH-1:0] r_out_data;

    // Flags
    logic                 r_wr_ready;
    logic                 r_overflow;

    // Per-cycle decisions
    logic                 w_wr_xfer;
    logic                 w_rd_xfer;
    logic                 w_out_load;
    logic                 w_ram_issue;
    logic                 w_refused;
    logic [CNT_W-1:0]     w_fill_next;
    logic [CNT_W-1:0]     w_ram_next;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wr_xfer   = bus.i_wr_valid & r_wr_ready;
        w_rd_xfer   = r_out_valid & bus.i_rd_ready;
        w_refused   = bus.i_wr_valid & ~r_wr_ready;
        // Output register takes the fetched word when it is empty or being read.
        w_out_load  = r_mid_valid & (~r_out_valid | w_rd_xfer);
        // Fetch from RAM when the fetch stage is empty or moving on this edge.
        w_ram_issue = (r_ram_count != '0) & (~r_mid_valid | w_out_load);

        w_fill_next = r_fill_count;
        if (w_wr_xfer && !w_rd_xfer) begin
            w_fill_next = r_fill_count + CNT_ONE;
        end else if (!w_wr_xfer && w_rd_xfer) begin
            w_fill_next = r_fill_count - CNT_ONE;
        end

        w_ram_next = r_ram_count;
        if (w_wr_xfer && !w_ram_issue) begin
            w_ram_next = r_ram_count + CNT_ONE;
        end else if (!w_wr_xfer && w_ram_issue) begin
            w_ram_next = r_ram_count - CNT_ONE;
        end
    end

    // NOTE: the RAM array and its read register carry no reset; their contents
    // are meaningless until the pointers and valid bits say otherwise, and
    // leaving them unreset lets the array map onto block RAM.
    // A fetch never targets the slot being written: a fetch needs a word
    // already in RAM, and a write needs a free slot, so the two pointers
    // can only coincide when the RAM is completely full or empty.
    always_ff @(posedge clk) begin
        if (w_wr_xfer) begin
            r_mem[r_wr_ptr] <= bus.i_wr_data;
        end
        if (w_ram_issue) begin
            r_mid_data <= r_mem[r_rd_ptr];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_fill_count <= '0;
            r_mid_valid  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_wr_ready   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_wr_xfer) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;   // wraps modulo RAM_DEPTH
            end
            if (w_ram_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_ram_count  <= w_ram_next;
            r_fill_count <= w_fill_next;

            if (w_ram_issue) begin
                r_mid_valid <= 1'b1;
            end else if (w_out_load) begin
                r_mid_valid <= 1'b0;
            end

            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mid_data;
            end else if (w_rd_xfer) begin
                r_out_valid <= 1'b0;
            end

            // Ready is a pure register so no input reaches it combinationally.
            r_wr_ready <= (w_fill_next < DEPTH_LVL);

            // Setting wins over clearing in the same cycle.
            if (w_refused) begin
                r_overflow <= 1'b1;
            end else if (i_clear_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_RING_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (i_clear_err) begin
            // A refusal in the clearing cycle is the first one counted afresh.
            r_drop_count <= w_refused ? 16'd1 : 16'd0;
        end else if (w_refused && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_drop_count = r_drop_count;
`endif

    assign bus.o_wr_ready = r_wr_ready;
    assign bus.o_rd_valid = r_out_valid;
    assign bus.o_rd_data  = r_out_data;
    assign o_fill_count   = r_fill_count;
    assign o_almost_full  = (r_fill_count >= AF_LVL);
    assign o_almost_empty = (r_fill_count <= AE_LVL);
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_fifo_ring_fwft.sv
// ---------------------------------------------------------------------------
// tb_fifo_ring_fwft
//   Directed bench for fifo_ring_fwft (RAM_WIDTH=32, RAM_DEPTH=8,
//   AF_THRESH=6, AE_THRESH=2). A queue model holds each accepted word with
//   the edge at which it was written; the head is visible once two edges
//   have passed since its write. A negedge process compares every output
//   with the model each cycle; the directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_fifo_ring_fwft;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_err;
    logic [3:0] fill_count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
`ifdef FIFO_RING_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    fifo_ring_fwft_if #(.RAM_WIDTH(W)) bus ();

    fifo_ring_fwft #(
        .RAM_WIDTH (W),
        .RAM_DEPTH (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .o_fill_count   (fill_count),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .i_clear_err    (clear_err),
        .o_overflow     (overflow)
`ifdef FIFO_RING_DROP_COUNT_EN
        ,
        .o_drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: queue of (data, write edge); everything else follows from it.
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] data;
        int           stamp;
    } entry_t;

    entry_t      m_q[$];
    int          m_edge     = 0;
    bit          m_live     = 0;
    bit          m_wr_ready = 0;
    bit          m_rd_valid = 0;
    bit          m_ovf      = 0;
    bit          m_loaded   = 0;
    int          m_drop     = 0;

    task automatic model_step();
        bit wr_x;
        bit rd_x;
        bit refused;
        entry_t e;
        m_edge++;
        if (rst) begin
            m_q.delete();
            m_wr_ready = 0;
            m_ovf      = 0;
            m_drop     = 0;
            m_loaded   = 0;
            m_live     = 1;
        end else begin
            wr_x    = bus.i_wr_valid && m_wr_ready;
            rd_x    = m_rd_valid && bus.i_rd_ready;
            refused = bus.i_wr_valid && !m_wr_ready;
            if (rd_x) void'(m_q.pop_front());
            if (wr_x) begin
                e.data  = bus.i_wr_data;
                e.stamp = m_edge;
                m_q.push_back(e);
            end
            if (refused) m_ovf = 1;
            else if (clear_err) m_ovf = 0;
            if (clear_err) m_drop = refused ? 1 : 0;
            else if (refused && m_drop < 65535) m_drop++;
            m_wr_ready = (m_q.size() < DEPTH);
        end
        m_rd_valid = (m_q.size() > 0) && (m_q[0].stamp + 2 <= m_edge);
        if (m_rd_valid) m_loaded = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("wr_ready",     64'(bus.o_wr_ready), 64'(m_wr_ready));
            check("rd_valid",     64'(bus.o_rd_valid), 64'(m_rd_valid));
            check("fill_count",   64'(fill_count),     64'(m_q.size()));
            check("almost_full",  64'(almost_full),    64'(m_q.size() >= AF));
            check("almost_empty", 64'(almost_empty),   64'(m_q.size() <= AE));
            check("overflow",     64'(overflow),       64'(m_ovf));
            if (m_rd_valid) check("rd_data", 64'(bus.o_rd_data), 64'(m_q[0].data));
            else if (!m_loaded) check("rd_data_zero", 64'(bus.o_rd_data), 64'd0);
`ifdef FIFO_RING_DROP_COUNT_EN
            check("drop_count", 64'(drop_count), 64'(m_drop));
`endif
        end
    end

    // Words actually handed over by the DUT.
    logic [W-1:0] got[$];
    initial forever begin
        @(posedge clk);
        if (!rst && bus.o_rd_valid === 1'b1 && bus.i_rd_ready === 1'b1)
            got.push_back(bus.o_rd_data);
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr, input logic clr);
        bus.i_wr_valid = wv;
        bus.i_wr_data  = wd;
        bus.i_rd_ready = rr;
        clear_err      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_ready = 1'b0;
        clear_err      = 1'b0;
        idle(2);
        check("rst_wr_ready", 64'(bus.o_wr_ready), 64'd0);
        check("rst_aempty",   64'(almost_empty),   64'd1);
        check("rst_rd_data",  64'(bus.o_rd_data),  64'd0);
        rst = 1'b0;
        idle(1);
        check("wr_ready_after_rst", 64'(bus.o_wr_ready), 64'd1);

        // Fall-through latency of two edges.
        step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        idle(1);
        check("a5_not_yet_valid", 64'(bus.o_rd_valid), 64'd0);
        idle(1);
        check("a5_valid", 64'(bus.o_rd_valid), 64'd1);
        check("a5_data",  64'(bus.o_rd_data),  64'hA5A5A5A5);
        check("a5_fill",  64'(fill_count),     64'd1);
        drain(1);

        // Fill to capacity, refused write, overflow set/clear priority.
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        check("full_wr_ready", 64'(bus.o_wr_ready), 64'd0);
        check("full_fill",     64'(fill_count),     64'd8);
        check("full_afull",    64'(almost_full),    64'd1);
        check("model_full",    64'(m_q.size()),     64'd8);
        check("model_head",    64'(m_q[0].data),    64'd1);
        step(1'b1, 32'd9, 1'b0, 1'b0);
        check("ovf_set", 64'(overflow), 64'd1);
`ifdef FIFO_RING_DROP_COUNT_EN
        check("drop_one", 64'(drop_count), 64'd1);
`endif
        step(1'b1, 32'd10, 1'b0, 1'b1);
        check("ovf_set_beats_clear", 64'(overflow), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(overflow), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            check("readout", 64'(bus.o_rd_data), 64'(i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("readout_empty", 64'(bus.o_rd_valid), 64'd0);

        // Streaming through the pointer wrap.
        got.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            if (i >= 2) begin
                check("stream_fill",  64'(fill_count),     64'd3);
                check("stream_valid", 64'(bus.o_rd_valid), 64'd1);
            end
        end
        drain(3);
        check("stream_count", 64'(got.size()), 64'd20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            check("stream_order", 64'(got[i]), 64'(i));

        // Simultaneous write and read at fill_count = DEPTH-1.
        for (int i = 0; i < 7; i++) step(1'b1, W'(100 + i), 1'b0, 1'b0);
        check("fill7", 64'(fill_count), 64'd7);
        step(1'b1, 32'd107, 1'b1, 1'b0);
        check("fill7_both_fill", 64'(fill_count),     64'd7);
        check("fill7_both_head", 64'(bus.o_rd_data),  64'd101);
        step(1'b1, 32'd108, 1'b1, 1'b0);
        check("fill7_again_fill", 64'(fill_count),    64'd7);
        check("fill7_again_head", 64'(bus.o_rd_data), 64'd102);
        drain(7);
        check("fill7_drained", 64'(fill_count), 64'd0);

        // Stalled consumer with three words queued.
        step(1'b1, 32'd200, 1'b0, 1'b0);
        check("ae_fill1", 64'(almost_empty), 64'd1);
        step(1'b1, 32'd201, 1'b0, 1'b0);
        check("ae_fill2", 64'(almost_empty), 64'd1);
        step(1'b1, 32'd202, 1'b0, 1'b0);
        check("ae_fill3", 64'(almost_empty), 64'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("stall_data",  64'(bus.o_rd_data), 64'd200);
            check("stall_aempty", 64'(almost_empty), 64'd0);
        end

        // Reset mid-operation with five words queued and overflow set.
        for (int i = 3; i < 8; i++) step(1'b1, W'(200 + i), 1'b0, 1'b0);
        step(1'b1, 32'd208, 1'b0, 1'b0);
        drain(3);
        check("pre_rst_fill", 64'(fill_count), 64'd5);
        check("pre_rst_ovf",  64'(overflow),   64'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_fill",     64'(fill_count),     64'd0);
        check("midrst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        check("midrst_ovf",      64'(overflow),       64'd0);
        check("midrst_wr_ready", 64'(bus.o_wr_ready), 64'd0);
        check("midrst_rd_data",  64'(bus.o_rd_data),  64'd0);
        idle(1);
        check("midrst_ready_back", 64'(bus.o_wr_ready), 64'd1);
        step(1'b1, 32'd300, 1'b0, 1'b0);
        idle(1);
        check("post_rst_not_yet", 64'(bus.o_rd_valid), 64'd0);
        idle(1);
        check("post_rst_valid", 64'(bus.o_rd_valid), 64'd1);
        check("post_rst_data",  64'(bus.o_rd_data),  64'd300);
        drain(1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
